// File: rtl/fp_pack_pkg.sv
`default_nettype none
// ============================================================
// Module   : fp_pack_pkg
// Purpose  : Shared types and sizing helpers for the lane packer.
// Revision : 1.0
// ============================================================
package fp_pack_pkg;

    localparam int c_DEFAULT_EXPONENT_SIZE = 8;
    localparam int c_DEFAULT_MANTISSA_SIZE = 7;
    localparam int c_DEFAULT_CONV_LATENCY  = 5;

    function automatic int fp_width(input int e, input int m);
        return 1 + e + m;
    endfunction

    typedef struct packed {
        logic                               sign;
        logic [c_DEFAULT_EXPONENT_SIZE-1:0] exponent;
        logic [c_DEFAULT_MANTISSA_SIZE-1:0] mantissa;
    } fp_lane_t;

endpackage
`default_nettype wire

// File: rtl/fp_pack_fifo.sv
`default_nettype none
// ============================================================
// Module   : fp_pack_fifo
// Purpose  : First-word-fall-through FIFO with occupancy count.
// Revision : 1.0
// ============================================================
module fp_pack_fifo #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int COUNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic [WIDTH-1:0]   i_push_data,
    input  logic               i_pop,
    output logic [WIDTH-1:0]   o_pop_data,
    output logic               o_empty,
    output logic [COUNT_W-1:0] o_count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [COUNT_W-1:0] r_count;
    logic               w_full;
    logic               w_push_en;
    logic               w_pop_en;

    function automatic logic [c_AW-1:0] ptr_inc(input logic [c_AW-1:0] p);
        return (p == c_AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == COUNT_W'(DEPTH));
    assign w_push_en = i_push && !w_full;
    assign w_pop_en  = i_pop && !o_empty;

    // Storage is deliberately left out of reset; only pointers and count matter.
    always_ff @(posedge clk) begin
        if (w_push_en) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_en) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop_en) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            unique case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(i_push && w_full));

endmodule
`default_nettype wire

// File: rtl/fp_lane_packer.sv
`default_nettype none
// ============================================================
// Module   : fp_lane_packer
// Purpose  : Packs converter float outputs into LANES-wide words
//            behind a credit-gated input and an output FIFO.
// Revision : 1.0
// ============================================================
module fp_lane_packer
    import fp_pack_pkg::*;
#(
    parameter int EXPONENT_SIZE = c_DEFAULT_EXPONENT_SIZE,
    parameter int MANTISSA_SIZE = c_DEFAULT_MANTISSA_SIZE,
    parameter int CONV_LATENCY  = c_DEFAULT_CONV_LATENCY,
    parameter int LANES         = 4,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               in_valid,
    input  logic                                               in_last,
    output logic                                               in_ready,
    input  logic                                               fp_sign,
    input  logic [EXPONENT_SIZE-1:0]                           fp_exponent,
    input  logic [MANTISSA_SIZE-1:0]                           fp_mantissa,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic [LANES*fp_width(EXPONENT_SIZE,MANTISSA_SIZE)-1:0] out_data,
    output logic [LANES-1:0]                                   out_keep,
    output logic                                               out_last
);

    localparam int c_W      = fp_width(EXPONENT_SIZE, MANTISSA_SIZE);
    localparam int c_DATA_W = LANES * c_W;
    localparam int c_IDX_W  = $clog2(LANES);
    localparam int c_FIFO_W = c_DATA_W + LANES + 1;
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int c_INF_W  = $clog2(CONV_LATENCY + 1);
    localparam int c_SUM_W  = $clog2(FIFO_DEPTH + CONV_LATENCY + 1);

    logic [CONV_LATENCY-1:0] r_dly_vld;
    logic [CONV_LATENCY-1:0] r_dly_last;
    logic [c_INF_W-1:0]      r_inflight;
    logic [c_IDX_W-1:0]      r_idx;
    logic [c_DATA_W-1:0]     r_data;
    logic [LANES-1:0]        r_keep;

    logic                    w_accept;
    logic                    w_land;
    logic                    w_land_last;
    logic                    w_close;
    logic [c_W-1:0]          w_lane;
    logic [c_DATA_W-1:0]     w_data_merged;
    logic [LANES-1:0]        w_keep_merged;
    logic [c_FIFO_W-1:0]     w_push_data;
    logic [c_FIFO_W-1:0]     w_pop_data;
    logic [c_CNT_W-1:0]      w_fifo_count;
    logic                    w_fifo_empty;
    logic                    w_pop;
    logic [c_DATA_W-1:0]     w_q_data;
    logic [LANES-1:0]        w_q_keep;
    logic                    w_q_last;

    assign w_accept    = in_valid && in_ready;
    assign w_land      = r_dly_vld[CONV_LATENCY-1];
    assign w_land_last = r_dly_last[CONV_LATENCY-1];
    assign w_lane      = {fp_sign, fp_exponent, fp_mantissa};

    // Every in-flight sample may close a word, so it holds a FIFO credit until it lands.
    assign in_ready = (c_SUM_W'(w_fifo_count) + c_SUM_W'(r_inflight)) < c_SUM_W'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly_vld  <= '0;
            r_dly_last <= '0;
        end else begin
            r_dly_vld[0]  <= w_accept;
            r_dly_last[0] <= w_accept && in_last;
            for (int i = 1; i < CONV_LATENCY; i++) begin
                r_dly_vld[i]  <= r_dly_vld[i-1];
                r_dly_last[i] <= r_dly_last[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            unique case ({w_accept, w_land})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_data_merged = r_data;
        w_keep_merged = r_keep;
        w_data_merged[r_idx*c_W +: c_W] = w_lane;
        w_keep_merged[r_idx]            = 1'b1;
    end

    assign w_close     = w_land && ((r_idx == c_IDX_W'(LANES - 1)) || w_land_last);
    assign w_push_data = {w_data_merged, w_keep_merged, w_land_last};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_data <= '0;
            r_keep <= '0;
        end else if (w_land) begin
            if (w_close) begin
                r_idx  <= '0;
                r_data <= '0;
                r_keep <= '0;
            end else begin
                r_idx  <= r_idx + 1'b1;
                r_data <= w_data_merged;
                r_keep <= w_keep_merged;
            end
        end
    end

    fp_pack_fifo #(
        .WIDTH   (c_FIFO_W),
        .DEPTH   (FIFO_DEPTH),
        .COUNT_W (c_CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_close),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign out_valid = !w_fifo_empty;
    assign w_pop     = out_valid && out_ready;
    assign {w_q_data, w_q_keep, w_q_last} = w_pop_data;

    // Mask unreset FIFO storage so outputs read zero whenever nothing is presented.
    assign out_data = out_valid ? w_q_data : '0;
    assign out_keep = out_valid ? w_q_keep : '0;
    assign out_last = out_valid && w_q_last;

endmodule
`default_nettype wire

// File: doc/fp_lane_packer.md
# fp_lane_packer

Downstream stage for the integer-to-float converter. It tracks which converter output cycles hold real samples and gathers LANES consecutive `{sign, exponent, mantissa}` results into one wide word. It buffers packed words in a small FIFO and presents them on a valid/ready stream. The converter cannot stall, so this block issues credit-based `in_ready` back to the converter's producer so that no sample is ever dropped.

## Interface
Parameters:
- EXPONENT_SIZE, 8, exponent width of converter output
- MANTISSA_SIZE, 7, mantissa width of converter output
- CONV_LATENCY, 5, cycles from converter `din` to its `sign/exponent/mantissa`; must be ≥1
- LANES, 4, floats per output word; must be ≥2
- FIFO_DEPTH, 8, output FIFO entries; must be > CONV_LATENCY+1

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  sample presented on converter `din` this cycle
- in_last  in  1  marks the final sample of a group; qualified by in_valid
- in_ready  out  1  producer may assert in_valid this cycle
- fp_sign  in  1  converter sign output
- fp_exponent  in  EXPONENT_SIZE  converter exponent output
- fp_mantissa  in  MANTISSA_SIZE  converter mantissa output
- out_valid  out  1  out_data/out_keep/out_last valid
- out_ready  in  1  consumer accepts the word
- out_data  out  LANES*W  packed word; W = 1+EXPONENT_SIZE+MANTISSA_SIZE
- out_keep  out  LANES  one bit per populated lane
- out_last  out  1  word closes a group

## Operation
- A sample is accepted when `in_valid && in_ready`. Accepted samples and their in_last flag travel down a CONV_LATENCY-deep shift register, so they align with the fp_* outputs.
- `inflight` counter: +1 on accept, −1 when a sample exits the delay line; range 0..CONV_LATENCY.
- Accumulator holds a lane index 0..LANES-1, a data register and a keep register. An arriving sample is written into lane `idx` as `{sign, exponent, mantissa}`, with lane 0 in the LSBs, and sets `keep[idx]`.
- A word closes when `idx == LANES-1` or when the arriving sample's last flag is set. On close:
  - push `{data, keep, last}` to the FIFO;
  - clear data and keep; idx returns to 0.
  - Lanes that were not populated output zero data and keep=0.
- Otherwise idx increments.
- Credit rule: `in_ready = (fifo_count + inflight) < FIFO_DEPTH`. Each in-flight sample can close at most one word, so a FIFO push is never blocked. Asserting push while the FIFO is full is an assertion-checked error.
- The FIFO is first-word-fall-through. A pop happens on `out_valid && out_ready`. Push and pop in the same cycle leave the count unchanged.
- out_data, out_keep and out_last are stable while `out_valid && !out_ready`.
- in_last asserted without in_valid is ignored.

## Timing
- Reset values: out_valid=0, out_data=0, out_keep=0, out_last=0, in_ready=1. The delay line, inflight, idx, accumulator and FIFO are all cleared.
- Latency: a closing sample accepted at cycle t reaches the accumulator at t+CONV_LATENCY and is pushed at that edge. It appears as out_valid=1 at t+CONV_LATENCY+1 when the FIFO was empty.
- Throughput: with out_ready held at 1 there is one sample per cycle and in_ready never deasserts, because fifo_count ≤ 1 and inflight ≤ CONV_LATENCY.
- Back-pressure: when out_ready is held at 0, in_ready falls once `fifo_count + inflight` reaches FIFO_DEPTH. Samples already in flight still land.
- Reset asserted mid-operation discards every in-flight sample, the partial word and all FIFO contents, and takes effect immediately (asynchronous).

## Structure
- Package `fp_pack_pkg` holds:
  - `function fp_width(e, m)` returning 1+e+m;
  - typedef `fp_lane_t` packed struct {sign, exponent, mantissa}, for the default sizes;
  - localparam for the default CONV_LATENCY matching the 16-bit converter (5).
- One sub-module, `fp_pack_fifo`: a parameterised synchronous first-word-fall-through FIFO with count output and the same clk/rst_n. Its storage is not reset; only its pointers and count are reset.

## Test plan
- Steady stream: LANES=4, out_ready=1; lane sequences 0x3F80, 0x4000, 0x4040, 0x4080 are presented on fp_* at the aligned cycles → out_data=0x4080_4040_4000_3F80, keep=4'b1111, last=0, out_valid at accept+6. in_ready stays 1 throughout.
- Partial group: 2 samples 0x3F80, 0xBF80 with in_last on the second → out_data=0x0000_0000_BF80_3F80, keep=4'b0011, last=1; the next word starts at lane 0.
- Back-pressure: out_ready=0 with a continuous stream → in_ready drops to 0 exactly when fifo_count+inflight=8. No word is lost or duplicated after out_ready returns to 1, checked against a scoreboard.
- Last on the full lane: 4 samples with in_last on the 4th → exactly one word, keep=4'b1111, last=1. No empty word follows.
- Reset mid-stream: assert rst_n=0 with 3 samples in flight and FIFO holding 2 words → outputs take their reset values immediately. After release the first new sample lands in lane 0 with keep=4'b0001.
